// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed seven-segment scanner.
// A prescaler divides the clock into digit slots. The scan index walks across
// the four digits, one digit per slot. A full set of four character codes is
// captured into shadow registers only when the scan wraps from the leftmost
// digit back to the rightmost one. Because the display is driven from the
// shadow registers, changing the inputs in the middle of a frame cannot tear
// the picture.
module seven_segment_scanner #(
  parameter int DIV = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] BCD0,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD3,
  output logic [3:0] DIGIT,
  output logic [6:0] DISPLAY,
  output logic       frame_done
);

  localparam int               CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DIV - 1);
  localparam logic [3:0]       CODE_BLANK = 4'd9;

  // Segment patterns, active low, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_Y     = 7'b0010001;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       sh_q [4];
  logic [3:0]       sh_d [4];
  logic             frame_done_q, frame_done_d;
  logic             tick;
  logic             frame_latch;

  // Map a character code onto its segment pattern. Codes 9 and above are blank.
  function automatic logic [6:0] decode_char(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = SEG_P;
      4'd1:    seg = SEG_L;
      4'd2:    seg = SEG_A;
      4'd3:    seg = SEG_Y;
      4'd4:    seg = SEG_U;
      4'd5:    seg = SEG_S;
      4'd6:    seg = SEG_E;
      4'd7:    seg = SEG_H;
      4'd8:    seg = SEG_O;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Work out the next prescaler, scan index, shadow contents and frame pulse.
  always_comb begin
    tick         = (cnt_q == CNT_MAX);
    frame_latch  = tick && (idx_q == 2'd3);
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    frame_done_d = frame_latch;
    for (int i = 0; i < 4; i++) begin
      sh_d[i] = sh_q[i];
    end
    if (frame_latch) begin
      sh_d[0] = BCD0;
      sh_d[1] = BCD1;
      sh_d[2] = BCD2;
      sh_d[3] = BCD3;
    end
  end

  // State registers. Reset discards any partial frame and blanks the shadows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh_q[i] <= CODE_BLANK;
      end
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 4; i++) begin
        sh_q[i] <= sh_d[i];
      end
    end
  end

  // Drive one anode and its character straight from the scan index. The enable
  // only masks the outputs, so scanning keeps running while the display is dark.
  always_comb begin
    DIGIT   = 4'b1111;
    DISPLAY = SEG_BLANK;
    if (en) begin
      case (idx_q)
        2'd0:    DIGIT = 4'b1110;
        2'd1:    DIGIT = 4'b1101;
        2'd2:    DIGIT = 4'b1011;
        default: DIGIT = 4'b0111;
      endcase
      DISPLAY = decode_char(sh_q[idx_q]);
    end
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner with DIV=4.
// The stimulus pushes timestamped expectations. The monitor checks each
// expectation on the falling edge that follows its rising clock edge.
module tb_seven_segment_scanner;

  localparam int DIV = 4;

  localparam logic [6:0] P  = 7'b0001100;
  localparam logic [6:0] L  = 7'b1000111;
  localparam logic [6:0] A  = 7'b0001000;
  localparam logic [6:0] Y  = 7'b0010001;
  localparam logic [6:0] U  = 7'b1000001;
  localparam logic [6:0] S  = 7'b0010010;
  localparam logic [6:0] E  = 7'b0000110;
  localparam logic [6:0] H  = 7'b0001001;
  localparam logic [6:0] O  = 7'b1000000;
  localparam logic [6:0] BL = 7'b1111111;

  typedef struct {
    int         at;
    logic [3:0] digit;
    logic [6:0] disp;
    logic       fd;
    string      name;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       en;
  logic [3:0] BCD0, BCD1, BCD2, BCD3;
  logic [3:0] DIGIT;
  logic [6:0] DISPLAY;
  logic       frame_done;

  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  exp_t sb[$];

  seven_segment_scanner #(.DIV(DIV)) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .BCD0       (BCD0),
    .BCD1       (BCD1),
    .BCD2       (BCD2),
    .BCD3       (BCD3),
    .DIGIT      (DIGIT),
    .DISPLAY    (DISPLAY),
    .frame_done (frame_done)
  );

  // 10-time-unit clock with rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count rising edges so that every expectation can name the edge it belongs to.
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Insert an expectation, keeping the queue sorted by edge number.
  task automatic push_exp(input int at, input logic [3:0] d, input logic [6:0] s,
                          input logic f, input string n);
    exp_t e;
    int   pos;
    e.at    = at;
    e.digit = d;
    e.disp  = s;
    e.fd    = f;
    e.name  = n;
    pos     = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > at) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  // Compare the DUT outputs against one expectation.
  task automatic check_output(input exp_t e);
    checks++;
    if (DIGIT !== e.digit || DISPLAY !== e.disp || frame_done !== e.fd) begin
      errors++;
      $display("[TB] FAIL %s @edge %0d: got DIGIT=%b DISPLAY=%b fd=%b, want DIGIT=%b DISPLAY=%b fd=%b",
               e.name, e.at, DIGIT, DISPLAY, frame_done, e.digit, e.disp, e.fd);
    end
  endtask

  // Monitor: on each falling edge, pop every expectation that is due now.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
      exp_t e;
      e = sb.pop_front();
      if (e.at < edge_cnt) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s missed: due edge %0d, now edge %0d", e.name, e.at, edge_cnt);
      end else begin
        check_output(e);
      end
    end
  end

  // Return at #1 after the rising edge whose count reaches target.
  task automatic wait_until(input int target);
    while (edge_cnt < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Expect a blank frame (edges base+1 .. base+15): the anode walks and there is no pulse.
  task automatic push_blank_frame(input int base, input string n);
    logic [3:0] pat [4];
    pat[0] = 4'b1110;
    pat[1] = 4'b1101;
    pat[2] = 4'b1011;
    pat[3] = 4'b0111;
    for (int k = 1; k < 16; k++) begin
      push_exp(base + k, pat[k / 4], BL, 1'b0, n);
    end
  endtask

  task automatic set_bcd(input logic [3:0] b3, input logic [3:0] b2,
                         input logic [3:0] b1, input logic [3:0] b0);
    BCD3 = b3;
    BCD2 = b2;
    BCD1 = b1;
    BCD0 = b0;
  endtask

  task automatic apply_stimulus();
    int r;
    int r2;
    // Hold reset with the display enabled.
    reset = 1'b1;
    en    = 1'b1;
    set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      push_exp(k, 4'b1110, BL, 1'b0, "reset_hold");
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    r     = edge_cnt;

    // First frame: PLAY. It is blank until the latch at edge r+16.
    set_bcd(4'd0, 4'd1, 4'd2, 4'd3);
    push_blank_frame(r, "first_frame_blank");
    push_exp(r + 16, 4'b1110, Y, 1'b1, "latch_Y_pulse");
    push_exp(r + 17, 4'b1110, Y, 1'b0, "pulse_one_cycle");
    push_exp(r + 20, 4'b1101, A, 1'b0, "digit1_A");
    push_exp(r + 24, 4'b1011, L, 1'b0, "digit2_L");
    push_exp(r + 28, 4'b0111, P, 1'b0, "digit3_P");

    // Change BCD0 mid-frame. The frame shows nothing new until the wrap.
    wait_until(r + 21);
    BCD0 = 4'd8;
    push_exp(r + 22, 4'b1101, A, 1'b0, "no_tear_A");
    push_exp(r + 31, 4'b0111, P, 1'b0, "no_tear_P");
    push_exp(r + 32, 4'b1110, O, 1'b1, "wrap_shows_O");
    push_exp(r + 41, 4'b1011, L, 1'b0, "before_disable");

    // Disable for 10 cycles across a frame latch. The pulse timing must not change.
    wait_until(r + 42);
    en = 1'b0;
    for (int k = 42; k < 52; k++) begin
      push_exp(r + k, 4'b1111, BL, (k == 48), "disabled");
    end
    wait_until(r + 52);
    en = 1'b1;
    push_exp(r + 52, 4'b1101, A, 1'b0, "resume_idx1");

    // Codes 9, 10 and 15 are blank, and 7 is H on the leftmost digit.
    wait_until(r + 53);
    set_bcd(4'd7, 4'd15, 4'd10, 4'd9);
    push_exp(r + 60, 4'b0111, P, 1'b0, "old_frame_P");
    push_exp(r + 64, 4'b1110, BL, 1'b1, "code9_blank");
    push_exp(r + 68, 4'b1101, BL, 1'b0, "code10_blank");
    push_exp(r + 72, 4'b1011, BL, 1'b0, "code15_blank");
    push_exp(r + 76, 4'b0111, H, 1'b0, "code7_H");

    // Remaining characters: U, S, E, O.
    wait_until(r + 77);
    set_bcd(4'd8, 4'd6, 4'd5, 4'd4);
    push_exp(r + 80, 4'b1110, U, 1'b1, "code4_U");
    push_exp(r + 84, 4'b1101, S, 1'b0, "code5_S");
    push_exp(r + 88, 4'b1011, E, 1'b0, "code6_E");

    // Reset for one cycle while idx=2. The partial frame is discarded.
    wait_until(r + 89);
    reset = 1'b1;
    push_exp(r + 89, 4'b1110, BL, 1'b0, "async_reset");
    wait_until(r + 90);
    push_exp(r + 90, 4'b1110, BL, 1'b0, "reset_held");
    reset = 1'b0;
    r2    = edge_cnt;
    push_blank_frame(r2, "post_reset_blank");
    push_exp(r2 + 16, 4'b1110, U, 1'b1, "post_reset_latch");
    push_exp(r2 + 17, 4'b1110, U, 1'b0, "post_reset_pulse_end");
    push_exp(r2 + 20, 4'b1101, S, 1'b0, "post_reset_S");
  endtask

  initial begin
    apply_stimulus();
    for (int i = 0; i < 400 && sb.size() > 0; i++) begin
      @(posedge clock);
    end
    #1;
    if (sb.size() > 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("[TB] FAIL drain_timeout: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 Parameter: DIV, default 100000, meaning clock cycles per digit slot; legal range DIV >= 2.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  display enable; 0 blanks all digits.
REQ-005 BCD0  input  4  character code for the rightmost digit.
REQ-006 BCD1  input  4  character code for digit 1.
REQ-007 BCD2  input  4  character code for digit 2.
REQ-008 BCD3  input  4  character code for the leftmost digit.
REQ-009 DIGIT  output  4  active-low digit anodes; bit0 is the rightmost digit.
REQ-010 DISPLAY  output  7  active-low segments {g,f,e,d,c,b,a}; bit0 is segment a.
REQ-011 frame_done  output  1  one-cycle pulse when a new character frame is latched.

Function
REQ-012 Prescaler cnt, width ceil(log2(DIV)), SHALL increment every clock and return to 0 after DIV-1; tick is asserted in the cycle where cnt==DIV-1.
REQ-013 Scan index idx (2 bits) SHALL advance 0->1->2->3->0 on the clock edge where tick=1, and hold otherwise.
REQ-014 On the edge where tick=1 and idx==3, shadow registers SH0..SH3 SHALL capture BCD0..BCD3, and frame_done SHALL be 1 for exactly the following cycle.
REQ-015 BCDn changes between frame latches SHALL NOT affect DISPLAY; this prevents mid-frame tearing.
REQ-016 DIGIT SHALL be 4'b1110, 4'b1101, 4'b1011 or 4'b0111 for idx 0, 1, 2 or 3 respectively, decoded combinationally from idx.
REQ-017 DISPLAY SHALL be the combinational decode of SH[idx], with no pipeline latency relative to DIGIT.
REQ-018 Decode table, in the form code: character = DISPLAY value:
- 0: P = 0001100
- 1: L = 1000111
- 2: A = 0001000
- 3: Y = 0010001
- 4: U = 1000001
- 5: S = 0010010
- 6: E = 0000110
- 7: H = 0001001
- 8: O = 1000000
- 9: blank = 1111111
REQ-019 Codes 10..15 SHALL decode to blank, 1111111.
REQ-020 When en=0, DIGIT SHALL be 4'b1111 and DISPLAY SHALL be 7'b1111111 in the same cycle.
REQ-021 While en=0, cnt, idx, shadow latching and frame_done SHALL keep operating unaffected.
REQ-022 When en returns to 1, outputs SHALL resume immediately at the current idx.
REQ-023 No other output state SHALL exist; DIGIT SHALL never have more than one bit low.

Reset
REQ-024 While reset=1, and asynchronously upon its assertion: cnt=0, idx=0, SH0..SH3=9 (blank), frame_done=0.
REQ-025 After reset, with en=1, outputs SHALL be DIGIT=4'b1110 and DISPLAY=7'b1111111.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first latch after release occurs 4*DIV cycles after release.

Verification (DIV=4)
REQ-027 Assert reset, en=1 -> DIGIT=1110, DISPLAY=1111111 and frame_done=0 immediately; these values hold until release.
REQ-028 After release, drive BCD3..0=0,1,2,3 (PLAY):
- Ticks fall at cycles 4, 8, 12 and 16; outputs stay blank through the first three.
- At the edge of cycle 16: frame_done=1 for one cycle, DIGIT=1110, DISPLAY=0010001 (Y).
- Next ticks give DIGIT=1101 with 0001000 (A), then 1011 with 1000111 (L), then 0111 with 0001100 (P).
REQ-029 Change BCD0 from 3 to 8 while idx=1 -> the rightmost digit still shows Y until the next idx 3->0 wrap, then shows O (1000000).
REQ-030 Drive en=0 for 10 cycles mid-frame:
- DIGIT=1111 and DISPLAY=1111111 in the same cycles.
- idx and frame_done timing are unchanged versus an en=1 run.
REQ-031 Load codes 9, 10, 15 and 7 -> three blank digits, and H (0001001) on the leftmost digit.
REQ-032 Assert reset for 1 cycle when idx=2 -> idx=0, outputs blank and no frame_done pulse; the next frame_done comes 16 cycles after release.
